// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - parametrised VGA timing generator with selectable test patterns
//
// Purpose: free-running h/v counters produce sync and data-enable timing. A
// pattern engine colours each active pixel. Every output is registered one
// cycle after the counter state it describes, so all outputs stay mutually
// aligned.
//
// Ports:
//   clk          pixel clock
//   rst_n        synchronous active-low reset
//   mode         pattern select (0 frame, 1 bars, 2 bouncing box, 3 checker),
//                latched at the frame boundary
//   hsync/vsync  sync outputs, asserted level = SYNC_POL
//   de           active-video enable
//   vga_r/g/b    colour channels, COLOR_W bits each, zero outside active video
//   frame_start  one-cycle pulse alongside the first active pixel of a frame
module vga_pattern_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 56,
    parameter int H_SYNC     = 120,
    parameter int H_BP       = 64,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 37,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 23,
    parameter int SYNC_POL   = 0,
    parameter int COLOR_W    = 1,
    parameter int BORDER_W   = 20,
    parameter int BOX_SIZE   = 30,
    parameter int STEP       = 2,
    parameter int CHECK_LOG2 = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS    = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS    = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE    = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [HW-1:0] BRD_XL  = HW'(BORDER_W);
    localparam logic [HW-1:0] BRD_XH  = HW'(H_ACTIVE - BORDER_W);
    localparam logic [VW-1:0] BRD_YL  = VW'(BORDER_W);
    localparam logic [VW-1:0] BRD_YH  = VW'(V_ACTIVE - BORDER_W);
    localparam logic [HW-1:0] CX0     = HW'((H_ACTIVE - BOX_SIZE) / 2);
    localparam logic [HW-1:0] CX1     = HW'((H_ACTIVE - BOX_SIZE) / 2 + BOX_SIZE);
    localparam logic [VW-1:0] CY0     = VW'((V_ACTIVE - BOX_SIZE) / 2);
    localparam logic [VW-1:0] CY1     = VW'((V_ACTIVE - BOX_SIZE) / 2 + BOX_SIZE);

    localparam logic [HW-1:0] BX_MAX  = HW'(H_ACTIVE - BOX_SIZE);
    localparam logic [VW-1:0] BY_MAX  = VW'(V_ACTIVE - BOX_SIZE);
    localparam logic [HW-1:0] H_STEP  = HW'(STEP);
    localparam logic [VW-1:0] V_STEP  = VW'(STEP);
    localparam logic [HW:0]   BOX_HX  = (HW+1)'(BOX_SIZE);
    localparam logic [VW:0]   BOX_VX  = (VW+1)'(BOX_SIZE);
    // One bit wider than the position so the overshoot test cannot wrap.
    localparam logic [HW:0]   X_ADV   = (HW+1)'(BOX_SIZE + STEP);
    localparam logic [VW:0]   Y_ADV   = (VW+1)'(BOX_SIZE + STEP);
    localparam logic [HW:0]   H_ACT_X = (HW+1)'(H_ACTIVE);
    localparam logic [VW:0]   V_ACT_X = (VW+1)'(V_ACTIVE);

    localparam logic [BW-1:0]      BAR_LAST = BW'(BAR_W - 1);
    localparam logic [COLOR_W-1:0] FULL     = '1;
    localparam logic               SYNC_ON  = 1'(SYNC_POL);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [BW-1:0] bar_pix;
    logic [2:0]    bar_k;
    logic [1:0]    mode_q;
    logic [HW-1:0] bx;
    logic [VW-1:0] by;
    logic          dx;   // 1 = moving +x
    logic          dy;   // 1 = moving +y

    logic h_last, v_last, active, in_box;
    logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);
    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign in_box = (h_cnt >= bx) && ({1'b0, h_cnt} < ({1'b0, bx} + BOX_HX)) &&
                    (v_cnt >= by) && ({1'b0, v_cnt} < ({1'b0, by} + BOX_VX));

    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        case (mode_q)
            2'd0: begin
                if (h_cnt >= CX0 && h_cnt < CX1 && v_cnt >= CY0 && v_cnt < CY1)
                    pix_r = FULL;
                else if (h_cnt < BRD_XL || h_cnt >= BRD_XH || v_cnt < BRD_YL || v_cnt >= BRD_YH)
                    pix_g = FULL;
                else
                    pix_b = FULL;
            end
            2'd1: begin
                // Channel-on bits are 7-k, i.e. the complement of the bar index.
                pix_r = bar_k[2] ? '0 : FULL;
                pix_g = bar_k[1] ? '0 : FULL;
                pix_b = bar_k[0] ? '0 : FULL;
            end
            2'd2: begin
                if (in_box)
                    pix_r = FULL;
            end
            default: begin
                if (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) begin
                    pix_r = FULL;
                    pix_g = FULL;
                    pix_b = FULL;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            bar_pix     <= '0;
            bar_k       <= '0;
            mode_q      <= 2'd0;
            bx          <= '0;
            by          <= '0;
            dx          <= 1'b1;
            dy          <= 1'b1;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            de          <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last)
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;

            // Bar index tracks h_cnt: restarts with each line, steps every BAR_W pixels.
            if (h_last) begin
                bar_pix <= '0;
                bar_k   <= '0;
            end else if (h_cnt < H_ACT) begin
                if (bar_pix == BAR_LAST) begin
                    bar_pix <= '0;
                    bar_k   <= bar_k + 3'd1;
                end else begin
                    bar_pix <= bar_pix + 1'b1;
                end
            end

            if (h_last && v_last) begin
                mode_q <= mode;
                // The box only moves on frames that were displaying mode 2.
                if (mode_q == 2'd2) begin
                    if (dx) begin
                        if (({1'b0, bx} + X_ADV) > H_ACT_X) begin
                            bx <= BX_MAX;
                            dx <= 1'b0;
                        end else begin
                            bx <= bx + H_STEP;
                        end
                    end else begin
                        if (bx < H_STEP) begin
                            bx <= '0;
                            dx <= 1'b1;
                        end else begin
                            bx <= bx - H_STEP;
                        end
                    end
                    if (dy) begin
                        if (({1'b0, by} + Y_ADV) > V_ACT_X) begin
                            by <= BY_MAX;
                            dy <= 1'b0;
                        end else begin
                            by <= by + V_STEP;
                        end
                    end else begin
                        if (by < V_STEP) begin
                            by <= '0;
                            dy <= 1'b1;
                        end else begin
                            by <= by - V_STEP;
                        end
                    end
                end
            end

            hsync       <= (h_cnt >= H_SS && h_cnt < H_SE) ? SYNC_ON : ~SYNC_ON;
            vsync       <= (v_cnt >= V_SS && v_cnt < V_SE) ? SYNC_ON : ~SYNC_ON;
            de          <= active;
            vga_r       <= active ? pix_r : '0;
            vga_g       <= active ? pix_g : '0;
            vga_b       <= active ? pix_b : '0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - self-checking bench for vga_pattern_gen
module tb_vga_pattern_gen;
    localparam int HT    = 24;   // 16 + 2 + 3 + 3
    localparam int VT    = 16;   // 12 + 1 + 2 + 1
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       hsync, vsync, de, frame_start;
    logic [1:0] vga_r, vga_g, vga_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1), .COLOR_W(2), .BORDER_W(2), .BOX_SIZE(4),
        .STEP(5), .CHECK_LOG2(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .hsync(hsync), .vsync(vsync), .de(de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start)
    );

    typedef struct {
        logic [1:0] m;
        int         x;
        int         y;
        logic       e_de;
        logic [5:0] e_rgb;
    } vec_t;

    vec_t vecs[23];
    int   ebx[12];
    int   eby[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (frame_start !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_frame_start required=frame_start", tag);
        end
    endtask

    // Called on a frame_start sample; leaves the bench on the next frame's first pixel.
    task automatic scan_frame(input int f, input bit box_mode);
        int minx, miny, nred, nblank, nstray, x, y;
        minx = 99; miny = 99; nred = 0; nblank = 0; nstray = 0;
        check($sformatf("f%0d_start", f), 32'(frame_start), 32'd1);
        for (int k = 0; k < FRAME; k++) begin
            x = k % HT;
            y = k / HT;
            if (de !== 1'b1) begin
                if ({vga_r, vga_g, vga_b} !== 6'd0) nblank++;
            end else if ({vga_r, vga_g, vga_b} === 6'b110000) begin
                nred++;
                if (x < minx) minx = x;
                if (y < miny) miny = y;
            end else if (box_mode && {vga_r, vga_g, vga_b} !== 6'd0) begin
                nstray++;
            end
            @(negedge clk);
        end
        check($sformatf("f%0d_bx", f), 32'(minx), 32'(ebx[f]));
        check($sformatf("f%0d_by", f), 32'(miny), 32'(eby[f]));
        check($sformatf("f%0d_red_px", f), 32'(nred), 32'd16);
        check($sformatf("f%0d_blank_rgb", f), 32'(nblank), 32'd0);
        if (box_mode)
            check($sformatf("f%0d_stray_px", f), 32'(nstray), 32'd0);
    endtask

    initial begin
        int nhs, nvs, nde, nfs, first_hs, first_vs, n;

        //               mode   x   y  de    {r,g,b}
        vecs[0]  = '{2'd0,  1,  5, 1'b1, 6'b001100};
        vecs[1]  = '{2'd0,  7,  5, 1'b1, 6'b110000};
        vecs[2]  = '{2'd0,  4,  3, 1'b1, 6'b000011};
        vecs[3]  = '{2'd0, 14,  8, 1'b1, 6'b001100};
        vecs[4]  = '{2'd0, 13,  8, 1'b1, 6'b000011};
        vecs[5]  = '{2'd0, 10, 10, 1'b1, 6'b001100};
        vecs[6]  = '{2'd0,  6,  4, 1'b1, 6'b110000};
        vecs[7]  = '{2'd0, 10,  4, 1'b1, 6'b000011};
        vecs[8]  = '{2'd0,  9,  7, 1'b1, 6'b110000};
        vecs[9]  = '{2'd0, 17,  3, 1'b0, 6'b000000};
        vecs[10] = '{2'd1,  0,  0, 1'b1, 6'b111111};
        vecs[11] = '{2'd1,  1,  2, 1'b1, 6'b111111};
        vecs[12] = '{2'd1,  2,  2, 1'b1, 6'b111100};
        vecs[13] = '{2'd1,  5,  2, 1'b1, 6'b110011};
        vecs[14] = '{2'd1,  8,  2, 1'b1, 6'b001111};
        vecs[15] = '{2'd1, 15,  2, 1'b1, 6'b000000};
        vecs[16] = '{2'd1,  3, 13, 1'b0, 6'b000000};
        vecs[17] = '{2'd3,  4,  0, 1'b1, 6'b111111};
        vecs[18] = '{2'd3,  0,  0, 1'b1, 6'b000000};
        vecs[19] = '{2'd3,  4,  4, 1'b1, 6'b000000};
        vecs[20] = '{2'd3,  3,  5, 1'b1, 6'b111111};
        vecs[21] = '{2'd3,  8,  0, 1'b1, 6'b000000};
        vecs[22] = '{2'd3, 12,  1, 1'b1, 6'b111111};

        // Red-box corner per frame after the mid-line reset; frames 0 and 9 show mode 0.
        ebx = '{6, 0, 5, 10, 12, 7, 2, 0, 5, 6, 10, 12};
        eby = '{4, 0, 5,  8,  3, 0, 5, 8, 3, 4,  0,  5};

        rst_n = 1'b0;
        mode  = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_hsync", 32'(hsync), 32'd0);
        check("reset_vsync", 32'(vsync), 32'd0);
        check("reset_de", 32'(de), 32'd0);
        check("reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        check("reset_fs", 32'(frame_start), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check("first_fs", 32'(frame_start), 32'd1);
        check("first_de", 32'(de), 32'd1);
        check("first_rgb", 32'({vga_r, vga_g, vga_b}), 32'b001100);

        // One full frame of timing, starting at pixel (0,0).
        nhs = 0; nvs = 0; nde = 0; nfs = 0; first_hs = -1; first_vs = -1;
        for (int k = 0; k < FRAME; k++) begin
            if (hsync === 1'b1) begin
                nhs++;
                if (first_hs < 0) first_hs = k;
            end
            if (vsync === 1'b1) begin
                nvs++;
                if (first_vs < 0) first_vs = k;
            end
            if (de === 1'b1) nde++;
            if (frame_start === 1'b1) nfs++;
            @(negedge clk);
        end
        check("hsync_cycles", 32'(nhs), 32'd48);
        check("vsync_cycles", 32'(nvs), 32'd48);
        check("de_cycles", 32'(nde), 32'd192);
        check("fs_per_frame", 32'(nfs), 32'd1);
        check("hsync_first", 32'(first_hs), 32'd18);
        check("vsync_first", 32'(first_vs), 32'd312);
        check("frame_period", 32'(frame_start), 32'd1);

        foreach (vecs[i]) begin
            mode = vecs[i].m;
            wait_fs($sformatf("vec%0d", i));
            repeat (vecs[i].y * HT + vecs[i].x) @(negedge clk);
            check($sformatf("vec%0d_de", i), 32'(de), 32'(vecs[i].e_de));
            check($sformatf("vec%0d_rgb", i), 32'({vga_r, vga_g, vga_b}), 32'(vecs[i].e_rgb));
        end

        // Mode change mid-frame must wait for the next frame boundary.
        mode = 2'd1;
        wait_fs("toggle_a");
        repeat (6 * HT) @(negedge clk);
        mode = 2'd3;
        repeat (2 * HT + 2) @(negedge clk);
        check("toggle_same_frame_bars", 32'({vga_r, vga_g, vga_b}), 32'b111100);
        wait_fs("toggle_b");
        check("toggle_next_0_0", 32'({vga_r, vga_g, vga_b}), 32'd0);
        repeat (4) @(negedge clk);
        check("toggle_next_4_0", 32'({vga_r, vga_g, vga_b}), 32'b111111);

        // Reset while hsync is asserted, mid-line.
        n = 0;
        while (hsync !== 1'b1 && n < 2 * HT) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_hsync", 32'(hsync), 32'd1);
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("midreset%0d", c),
                  32'({hsync, vsync, de, vga_r, vga_g, vga_b, frame_start}), 32'd0);
        end
        rst_n = 1'b1;
        mode  = 2'd2;
        @(negedge clk);
        check("restart_de", 32'(de), 32'd1);

        for (int f = 0; f < 12; f++) begin
            if (f == 8) mode = 2'd0;
            if (f == 9) mode = 2'd2;
            scan_frame(f, (f != 0) && (f != 9));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
